// File: rtl/run_ctrl_if.sv
// Load stream and instruction-memory write port of run_ctrl.
// master = controller side, slave = load source / memory side.
interface run_ctrl_if #(
  parameter int INSTR_W = 16,
  parameter int AW      = 8
);
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               imem_we;
  logic [AW-1:0]      imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/run_ctrl.sv
// Load/reset/run sequencer: streams a program into imem (write lands in the accepting cycle), pulses core reset, then runs to halt/timeout.
// load_ready is high only in LOAD; optional stall detection is compiled in with `define RUN_CTRL_STALL_DET_EN.
module run_ctrl #(
  parameter int  PC_W            = 16,
  parameter int  INSTR_W         = 16,
  parameter int  MEM_DEPTH       = 256,
  parameter int  CORE_RST_CYCLES = 2,
  parameter int  STALL_LIMIT     = 16,
  localparam int AW              = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  run_ctrl_if.master      bus,
  output logic            core_rst,
  input  logic [PC_W-1:0] core_pc,
  input  logic [PC_W-1:0] halt_pc,
  input  logic [31:0]     cycle_limit,
  output logic [31:0]     cycle_count,
  output logic            done,
  output logic            timeout,
  output logic            stall,
  output logic            load_error
);

  if (CORE_RST_CYCLES < 1 || STALL_LIMIT < 1) begin : g_param_chk
    $error("run_ctrl: CORE_RST_CYCLES and STALL_LIMIT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CORE_RST,
    RUN,
    HALTED
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [31:0]   rcnt, rcnt_nxt;
  logic [31:0]   count_nxt;
  logic          done_nxt, timeout_nxt, lerr_nxt;
  logic          ready, accept;

`ifdef RUN_CTRL_STALL_DET_EN
  logic            stall_nxt;
  logic            stall_hit;
  logic            same_pc;
  logic [PC_W-1:0] prev_pc;
  logic [31:0]     same_cnt;
`endif

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    rcnt_nxt    = rcnt;
    count_nxt   = cycle_count;
    done_nxt    = done;
    timeout_nxt = timeout;
    lerr_nxt    = load_error;
`ifdef RUN_CTRL_STALL_DET_EN
    stall_nxt   = stall;
`endif
    ready       = 1'b0;
    accept      = 1'b0;
    core_rst    = 1'b1;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
        end
      end
      LOAD: begin
        ready  = 1'b1;
        accept = bus.load_valid;
        if (accept) begin
          addr_nxt = addr + AW'(1);
          // load_last wins over overflow, so a program that exactly fills memory still runs
          if (bus.load_last) begin
            state_nxt = CORE_RST;
            rcnt_nxt  = '0;
            count_nxt = '0;
          end else if (addr == AW'(MEM_DEPTH - 1)) begin
            state_nxt = HALTED;
            lerr_nxt  = 1'b1;
          end
        end
      end
      CORE_RST: begin
        if (rcnt == 32'(CORE_RST_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          rcnt_nxt = rcnt + 32'd1;
        end
      end
      RUN: begin
        core_rst = 1'b0;
        // the terminating cycle is not counted, so cycle_count equals the count it was compared at
        if (core_pc == halt_pc) begin
          state_nxt = HALTED;
          done_nxt  = 1'b1;
        end
`ifdef RUN_CTRL_STALL_DET_EN
        else if (stall_hit) begin
          state_nxt = HALTED;
          stall_nxt = 1'b1;
        end
`endif
        else if (cycle_limit != 32'd0 && cycle_count == cycle_limit) begin
          state_nxt   = HALTED;
          timeout_nxt = 1'b1;
        end else if (cycle_count != 32'hFFFF_FFFF) begin
          count_nxt = cycle_count + 32'd1;
        end
      end
      HALTED: begin
        if (start) begin
          state_nxt   = LOAD;
          addr_nxt    = '0;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          lerr_nxt    = 1'b0;
`ifdef RUN_CTRL_STALL_DET_EN
          stall_nxt   = 1'b0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.load_ready = ready;
  assign bus.imem_we    = accept;
  assign bus.imem_addr  = accept ? addr : '0;
  assign bus.imem_wdata = accept ? bus.load_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      rcnt        <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      rcnt        <= rcnt_nxt;
      cycle_count <= count_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
      load_error  <= lerr_nxt;
    end
  end

`ifdef RUN_CTRL_STALL_DET_EN
  // same_cnt holds how many earlier consecutive RUN cycles saw an unchanged PC
  assign same_pc   = (core_pc == prev_pc);
  assign stall_hit = same_pc && (same_cnt == 32'(STALL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc  <= '0;
      same_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      prev_pc  <= core_pc;
      same_cnt <= (state == RUN && same_pc) ? same_cnt + 32'd1 : 32'd0;
      stall    <= stall_nxt;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed sequences plus randomized load/run scenarios checked every cycle
// against a sequence-level model of what the controller must show.
`timescale 1ns/1ps
module tb_run_ctrl;
  localparam int PC_W      = 16;
  localparam int INSTR_W   = 16;
  localparam int MEM_DEPTH = 8;
  localparam int CRC       = 2;
  localparam int SLIM      = 16;
  localparam int AW        = $clog2(MEM_DEPTH);
`ifdef RUN_CTRL_STALL_DET_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, core_rst, done, timeout, stall, load_error;
  logic [PC_W-1:0] core_pc, halt_pc;
  logic [31:0]     cycle_limit, cycle_count;

  run_ctrl_if #(.INSTR_W(INSTR_W), .AW(AW)) bus ();

  run_ctrl #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_DEPTH(MEM_DEPTH),
    .CORE_RST_CYCLES(CRC), .STALL_LIMIT(SLIM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .core_rst(core_rst),
    .core_pc(core_pc), .halt_pc(halt_pc), .cycle_limit(cycle_limit),
    .cycle_count(cycle_count), .done(done), .timeout(timeout),
    .stall(stall), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // expected outputs for the cycle in progress
  bit                 e_lr, e_we, e_crst;
  int                 e_addr;
  logic [INSTR_W-1:0] e_wdata;
  logic [31:0]        m_count;
  bit                 m_done, m_timeout, m_stall, m_lerr;
  logic [PC_W-1:0]    pc_prev;

  int                 waddr_q[$];
  logic [INSTR_W-1:0] wdata_q[$];
  bit                 saw_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("load_ready",  32'(bus.load_ready), 32'(e_lr));
      check("imem_we",     32'(bus.imem_we),    32'(e_we));
      check("imem_addr",   32'(bus.imem_addr),  32'(e_addr));
      check("imem_wdata",  32'(bus.imem_wdata), 32'(e_wdata));
      check("core_rst",    32'(core_rst),       32'(e_crst));
      check("cycle_count", cycle_count,         m_count);
      check("done",        32'(done),           32'(m_done));
      check("timeout",     32'(timeout),        32'(m_timeout));
      check("stall",       32'(stall),          32'(m_stall));
      check("load_error",  32'(load_error),     32'(m_lerr));
      if (bus.imem_we === 1'b1) begin
        waddr_q.push_back(int'(bus.imem_addr));
        wdata_q.push_back(bus.imem_wdata);
      end
      if (core_rst === 1'b0) saw_run = 1'b1;
    end
  end

  task automatic tick();
    pc_prev = core_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit lr, input bit we, input int addr,
                         input logic [INSTR_W-1:0] wd, input bit crst);
    e_lr = lr; e_we = we; e_addr = addr; e_wdata = wd; e_crst = crst;
  endtask

  task automatic model_reset();
    m_count = '0; m_done = 0; m_timeout = 0; m_stall = 0; m_lerr = 0;
  endtask

  task automatic noise();
    bus.load_valid = 1'($urandom);
    bus.load_data  = 16'($urandom);
    bus.load_last  = 1'($urandom);
    start          = 1'($urandom);
  endtask

  task automatic do_start();
    noise();
    start = 1'b1;
    set_exp(0, 0, 0, '0, 1);
    tick();
    start = 1'b0;
    m_done = 0; m_timeout = 0; m_stall = 0; m_lerr = 0;
  endtask

  // res: 1 = program loaded, 0 = overflow, -1 = reset taken mid-load
  task automatic do_load(input int nwords, input bit with_last, input bit directed,
                         input int rst_at, output int res);
    int gaps;
    res = 0;
    for (int i = 0; i < nwords; i++) begin
      gaps = directed ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        noise();
        bus.load_valid = 1'b0;
        set_exp(1, 0, 0, '0, 1);
        tick();
      end
      noise();
      bus.load_valid = 1'b1;
      bus.load_last  = with_last && (i == nwords - 1);
      if (directed) bus.load_data = 16'(32'h1111 * (i + 1));
      set_exp(1, 1, i, bus.load_data, 1);
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        res = -1;
        return;
      end
      tick();
      if (with_last && i == nwords - 1) begin
        m_count = '0;
        res = 1;
        return;
      end
      if (i == MEM_DEPTH - 1) begin
        m_lerr = 1;
        res = 0;
        return;
      end
    end
  endtask

  task automatic do_core_rst(input logic [PC_W-1:0] pre_pc);
    for (int c = 0; c < CRC; c++) begin
      noise();
      core_pc = pre_pc;
      set_exp(0, 0, 0, '0, 1);
      tick();
    end
  endtask

  // mode 0: PC counts up from base; 1: random PC in 0..3; 2: PC held at base
  task automatic do_run(input int mode, input logic [PC_W-1:0] base, input int rst_at);
    int streak;
    bit hd, hs, ht;
    streak = 0;
    for (int k = 0; k < 400; k++) begin
      noise();
      case (mode)
        0:       core_pc = PC_W'(32'(base) + 32'(k));
        1:       core_pc = PC_W'($urandom_range(0, 3));
        default: core_pc = base;
      endcase
      m_count = 32'(k);
      set_exp(0, 0, 0, '0, 0);
      streak = (core_pc == pc_prev) ? streak + 1 : 0;
      hd = (core_pc == halt_pc);
      hs = STALL_ON && (streak == SLIM);
      ht = (cycle_limit != 0) && (32'(k) == cycle_limit);
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        return;
      end
      tick();
      if (hd) begin m_done = 1; return; end
      if (hs) begin m_stall = 1; return; end
      if (ht) begin m_timeout = 1; return; end
    end
    checks++;
    failures++;
    $display("FAIL run_bound: no termination within 400 run cycles at %0t", $time);
  endtask

  task automatic do_halted(input int n);
    for (int c = 0; c < n; c++) begin
      noise();
      start = 1'b0;
      set_exp(0, 0, 0, '0, 1);
      tick();
    end
  endtask

  initial begin
    int res;
    logic [INSTR_W-1:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst = 1'b1; start = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    core_pc = '0; halt_pc = '0; cycle_limit = '0;
    model_reset();
    set_exp(0, 0, 0, '0, 1);
    @(posedge clk);
    #1;
    check("rst_core_rst",   32'(core_rst), 32'd1);
    check("rst_load_ready", 32'(bus.load_ready), 32'd0);
    check("rst_imem_we",    32'(bus.imem_we), 32'd0);
    check("rst_imem_addr",  32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
    check("rst_count",      cycle_count, 32'd0);
    check("rst_flags",      32'({done, timeout, stall, load_error}), 32'd0);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // four-word program, halt at PC 50
    waddr_q.delete(); wdata_q.delete();
    halt_pc = 16'd50; cycle_limit = 32'd0;
    do_start();
    do_load(4, 1, 1, -1, res);
    check("prog_write_cnt", 32'(waddr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < waddr_q.size(); i++) begin
      check("prog_write_addr", 32'(waddr_q[i]), 32'(i));
      check("prog_write_data", 32'(wdata_q[i]), 32'(words[i]));
    end
    do_core_rst(16'hFFFF);
    check("prog_core_rst_released", 32'(core_rst), 32'd0);
    do_run(0, 16'd0, -1);
    check("halt_done",     32'(done), 32'd1);
    check("halt_count",    cycle_count, 32'd50);
    check("halt_core_rst", 32'(core_rst), 32'd1);
    check("halt_timeout",  32'(timeout), 32'd0);
    do_halted(3);

    // cycle limit 10, halt unreachable
    halt_pc = 16'hFFFF; cycle_limit = 32'd10;
    do_start();
    do_load(2, 1, 0, -1, res);
    do_core_rst(16'hFFF0);
    do_run(0, 16'd0, -1);
    check("limit_timeout", 32'(timeout), 32'd1);
    check("limit_done",    32'(done), 32'd0);
    check("limit_count",   cycle_count, 32'd10);
    do_halted(2);

    // overflow: full memory without load_last
    waddr_q.delete(); wdata_q.delete(); saw_run = 1'b0;
    do_start();
    do_load(MEM_DEPTH, 0, 0, -1, res);
    do_halted(3);
    check("ovf_load_error", 32'(load_error), 32'd1);
    check("ovf_write_cnt",  32'(waddr_q.size()), 32'(MEM_DEPTH));
    check("ovf_no_run",     32'(saw_run), 32'd0);

    // PC held at 7: stall (when built) beats the later timeout
    halt_pc = 16'd100; cycle_limit = 32'd40;
    do_start();
    do_load(1, 1, 0, -1, res);
    do_core_rst(16'd7);
    do_run(2, 16'd7, -1);
    check("hold_stall",   32'(stall), 32'(STALL_ON));
    check("hold_timeout", 32'(timeout), 32'(!STALL_ON));
    check("hold_count",   cycle_count, STALL_ON ? 32'd15 : 32'd40);
    do_halted(2);
    halt_pc = 16'd7;
    do_start();
    do_load(1, 1, 0, -1, res);
    do_core_rst(16'd7);
    do_run(2, 16'd7, -1);
    check("hold_halt_done",  32'(done), 32'd1);
    check("hold_halt_stall", 32'(stall), 32'd0);
    check("hold_halt_count", cycle_count, 32'd0);
    do_halted(2);

    // reset on the third load word, then a fresh load
    halt_pc = 16'hFFFF; cycle_limit = 32'd5;
    do_start();
    do_load(5, 1, 0, 2, res);
    check("mid_rst_we",      32'(bus.imem_we), 32'd0);
    check("mid_rst_flags",   32'({done, timeout, stall, load_error}), 32'd0);
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    waddr_q.delete(); wdata_q.delete();
    do_start();
    do_load(3, 1, 0, -1, res);
    check("reload_write_cnt", 32'(waddr_q.size()), 32'd3);
    if (waddr_q.size() > 0) check("reload_first_addr", 32'(waddr_q[0]), 32'd0);
    do_core_rst(16'h0100);
    do_run(1, 16'd0, -1);
    do_halted(2);

    for (int it = 0; it < 30; it++) begin
      int mode, nw, rl, rr;
      bit err;
      logic [PC_W-1:0] base;
      mode = int'($urandom_range(0, 2));
      err  = ($urandom_range(0, 5) == 0);
      base = PC_W'($urandom_range(0, 1000));
      rl = -1; rr = -1;
      if ($urandom_range(0, 7) == 0) rl = int'($urandom_range(0, 3));
      else if ($urandom_range(0, 7) == 0) rr = int'($urandom_range(0, 8));
      nw = err ? MEM_DEPTH : int'($urandom_range(1, MEM_DEPTH));
      case (mode)
        0: begin
          halt_pc     = PC_W'(32'(base) + $urandom_range(0, 60));
          cycle_limit = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 70));
        end
        1: begin
          halt_pc     = 16'd100;
          cycle_limit = 32'($urandom_range(1, 60));
        end
        default: begin
          halt_pc     = PC_W'(32'(base) + 32'd1);
          cycle_limit = 32'($urandom_range(5, 40));
        end
      endcase
      do_start();
      do_load(nw, !err, 0, rl, res);
      if (res == 1) begin
        do_core_rst((mode == 2) ? base : PC_W'($urandom));
        do_run(mode, base, rr);
      end
      do_halted(int'($urandom_range(1, 3)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16, core program-counter width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, instruction memory depth in words; AW = $clog2(MEM_DEPTH).
REQ-004 SHALL have parameter CORE_RST_CYCLES, default 2, core reset pulse length in cycles (>=1).
REQ-005 SHALL have parameter STALL_LIMIT, default 16, consecutive unchanged-PC cycles that count as a stall.
REQ-006 SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  single-cycle request to begin a load/run sequence.
REQ-010 load_valid  in  1  load word valid.
REQ-011 load_data  in  INSTR_W  load word.
REQ-012 load_last  in  1  marks the final load word.
REQ-013 load_ready  out  1  controller accepts a load word.
REQ-014 imem_we  out  1  instruction memory write strobe.
REQ-015 imem_addr  out  AW  instruction memory write address.
REQ-016 imem_wdata  out  INSTR_W  instruction memory write data.
REQ-017 core_rst  out  1  reset to the core, active-high.
REQ-018 core_pc  in  PC_W  core next-PC.
REQ-019 halt_pc  in  PC_W  PC value that ends the run.
REQ-020 cycle_limit  in  32  maximum run cycles; 0 = unlimited.
REQ-021 cycle_count  out  32  cycles spent in RUN.
REQ-022 done, timeout, stall, load_error  out  1 each  sticky termination flags.

Function
REQ-023 FSM states: IDLE, LOAD, CORE_RST, RUN, HALTED.
REQ-024 IDLE: core_rst=1, load_ready=0; start -> LOAD with the write address at 0.
REQ-025 LOAD: load_ready=1; each load_valid&load_ready cycle drives imem_we=1, imem_addr=address, imem_wdata=load_data in that same cycle, then increments the address.
REQ-026 LOAD: an accepted word with load_last=1 -> CORE_RST.
REQ-027 LOAD: an accepted word at address MEM_DEPTH-1 with load_last=0 -> HALTED, load_error=1; the word is still written.
REQ-028 CORE_RST: core_rst=1 for exactly CORE_RST_CYCLES cycles, then RUN; cycle_count cleared to 0 on entry.
REQ-029 RUN: core_rst=0; cycle_count increments by 1 each cycle and saturates at 32'hFFFFFFFF.
REQ-030 RUN: core_pc==halt_pc -> HALTED next cycle with done=1.
REQ-031 RUN: cycle_limit!=0 and cycle_count==cycle_limit -> HALTED with timeout=1.
REQ-032 Simultaneous RUN terminations: done > stall > timeout; only the winning flag is set.
REQ-033 HALTED: core_rst=1, load_ready=0; flags and cycle_count hold; start clears all flags and -> LOAD at address 0.
REQ-034 start SHALL be ignored in LOAD, CORE_RST and RUN.
REQ-035 imem_we SHALL be 0 outside accepted LOAD cycles.

Reset
REQ-036 rst -> IDLE; core_rst=1; load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cycle_count=0, all flags 0.
REQ-037 rst asserted in any state, including mid-LOAD or mid-RUN, SHALL take effect on the next clk edge and discard the sequence in progress.

Configuration
REQ-038 Macro RUN_CTRL_STALL_DET_EN SHALL compile in stall detection.
REQ-039 Defined: in RUN, a counter counts consecutive cycles in which core_pc equals its registered previous value; reaching STALL_LIMIT -> HALTED with stall=1; any PC change resets the counter to 0.
REQ-040 Undefined: the stall port remains, tied to 0; no stall logic is built.

Verification
REQ-041 start, 4 words 0x1111..0x4444, last on the 4th -> writes at addresses 0..3, core_rst high 2 cycles, then RUN.
REQ-042 halt_pc=50, core_pc steps by 1 from 0 -> done=1 on the cycle after PC 50, core_rst=1, cycle_count=50.
REQ-043 cycle_limit=10, PC never reaches halt_pc -> timeout=1, cycle_count=10.
REQ-044 MEM_DEPTH=8, 8 words with no load_last -> load_error=1, 8 writes performed, no RUN entered.
REQ-045 RUN_CTRL_STALL_DET_EN defined, core_pc held at 7 -> stall=1 after 16 cycles; with halt_pc=7 the same stimulus gives done=1, stall=0.
REQ-046 rst pulsed at the 3rd load word -> IDLE, imem_we=0, flags 0; a fresh start then loads from address 0.
